// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The FSM walks IDLE -> ADD (one slice per cycle) -> DONE -> IDLE.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple slice adder with carry in/out; purely combinational, zero latency.
// No flow control: the result follows the inputs within the same cycle.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial W-bit adder: start accepted in IDLE, done pulses NIBBLES+1 cycles later.
// No queuing: start outside IDLE is dropped; results hold until the next accepted start.
module nibble_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    c_in,
  output logic                    busy,
  output logic                    done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    c_out,
  output logic                    ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]    idx;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                carry;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;
  logic                top_cin;
  logic                last;

  assign nib_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx*NIBBLE_W +: NIBBLE_W];
  assign last  = (idx == LAST_IDX);

  adder_4bit u_adder (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  // Carry into the MSB recovered from the slice's sum bit; only meaningful on the last slice.
  assign top_cin = nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1] ^ nib_s[NIBBLE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            idx   <= '0;
          end
        end
        ADD: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry <= nib_co;
          if (last) begin
            c_out <= nib_co;
            ovf   <= top_cin ^ nib_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq (NIBBLES=4): directed vectors, decoupled done monitor.
module tb_nibble_add_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int busy_cnt = 0;
  int last_done_cyc = -1;
  bit b2b_mode = 1'b0;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    wait_idle();
    a = ta; b = tb_v; c_in = tci; start = 1'b1;
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("accepted_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int base;
    int k;
    int n;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
          busy_cnt = 0;
        end else begin
          if (busy) busy_cnt++;
          if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("sum", {16'd0, sum}, {16'd0, e.s});
              chk("c_out", {31'd0, c_out}, {31'd0, e.c});
              chk("ovf", {31'd0, ovf}, {31'd0, e.o});
              chk("busy_len", busy_cnt, NIBBLES);
            end
            if (b2b_mode && last_done_cyc >= 0)
              chk("done_spacing", cyc - last_done_cyc, NIBBLES + 2);
            last_done_cyc = cyc;
            busy_cnt = 0;
          end
        end
      end
    join_none

    // Reset state, both while asserted and right after release.
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {14'd0, sum, c_out, ovf}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", {13'd0, busy, done, sum, c_out, ovf}, 32'd0);

    // Basic add plus explicit cycle-by-cycle latency.
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    for (int i = 1; i <= NIBBLES; i++) begin
      @(negedge clk);
      chk("lat_busy", {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk("lat_done", {30'd0, busy, done}, 32'd1);

    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Start pulsed mid-ADD must be ignored.
    wait_idle();
    base = n_done;
    do_op(16'h2468, 16'h1357, 1'b0, 16'h37BF, 1'b0, 1'b0);
    @(posedge clk);
    #1 a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("single_done", n_done - base, 32'd1);

    // Leave c_out/ovf at 1, then abort an op in its 3rd ADD cycle.
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    wait_idle();
    base = n_done;
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {13'd0, busy, done, sum, c_out, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", n_done - base, 32'd0);
    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // start held high: three back-to-back operations.
    wait_idle();
    a = 16'h0101; b = 16'h0202; c_in = 1'b0; start = 1'b1;
    b2b_mode = 1'b1;
    last_done_cyc = -1;
    for (int i = 0; i < 3; i++) exp_q.push_back({16'h0303, 1'b0, 1'b0});
    k = 0;
    n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) k++;
    end
    start = 1'b0;
    if (n >= 200) chk("b2b_timeout", 32'd1, 32'd0);
    wait_idle();
    repeat (8) @(negedge clk);
    b2b_mode = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 a  input  W  operand A; sampled only on the accepted start edge.
REQ-006 b  input  W  operand B; sampled only on the accepted start edge.
REQ-007 c_in  input  1  carry-in to nibble 0; sampled only on the accepted start edge.
REQ-008 busy  output  1  high while slices are being added.
REQ-009 done  output  1  one-cycle pulse; sum, c_out and ovf are valid.
REQ-010 sum  output  W  result A+B+c_in modulo 2^W.
REQ-011 c_out  output  1  carry out of the top nibble.
REQ-012 ovf  output  1  two's-complement signed overflow of the W-bit add.

Function
REQ-013 The block SHALL implement a registered FSM with states IDLE, ADD and DONE.
REQ-014 IDLE: start=1 SHALL capture a, b and c_in into internal registers, clear the slice index to 0 and go to ADD; start=0 SHALL stay in IDLE.
REQ-015 ADD: each cycle SHALL add captured nibble[idx] of A and B plus the carry register through one 4-bit adder, write the 4-bit result into sum[4*idx+3:4*idx], load its carry-out into the carry register and increment idx.
REQ-016 ADD SHALL go to DONE on the edge that processes idx = NIBBLES-1, so the ADD phase lasts exactly NIBBLES cycles.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 busy SHALL equal (state==ADD), and done SHALL equal (state==DONE), both decoded from registered state.
REQ-019 Latency: if start is accepted on edge k, done SHALL be high during the cycle after edge k+NIBBLES.
REQ-020 c_out SHALL equal the final carry register value, and ovf SHALL equal the carry into the top bit XOR the carry out of the top bit, both registered on the last ADD edge.
REQ-021 sum, c_out and ovf SHALL hold their values from the end of DONE until the next accepted start. Their values during ADD are undefined to users.
REQ-022 start asserted in ADD or DONE SHALL be ignored, with no queuing; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-023 The idx counter SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1, and SHALL never wrap during ADD.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, idx=0, carry=0, sum=0, c_out=0, ovf=0, busy=0 and done=0, including mid-ADD, which aborts the operation with no done pulse.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where start=1.

Structure
REQ-026 A shared package nibble_seq_pkg SHALL hold the state enum (IDLE, ADD, DONE) and the constant NIBBLE_W=4.
REQ-027 The datapath SHALL instantiate the existing adder_4bit exactly once as its sub-module; no other arithmetic SHALL produce sum.

Verification (NIBBLES=4)
REQ-028 a=16'h0001, b=16'h0001, c_in=0, start for 1 cycle -> busy high for 4 cycles; done high on the 5th cycle after the start edge; sum=16'h0002, c_out=0, ovf=0.
REQ-029 a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1, ovf=0; the carry ripples through all 4 slices.
REQ-030 a=16'h7FFF, b=16'h0001 -> sum=16'h8000, c_out=0, ovf=1. Also a=16'h00FF, b=0, c_in=1 -> sum=16'h0100.
REQ-031 New start pulsed during the 2nd ADD cycle with different operands -> ignored; the result equals the first operation, and exactly one done pulse occurs.
REQ-032 rst_n pulled low during the 3rd ADD cycle -> all outputs 0 asynchronously and no done pulse. A subsequent start with 16'h1234+16'h1111 -> sum=16'h2345.
REQ-033 start held high continuously -> back-to-back operations, with done pulses spaced NIBBLES+2 cycles apart.
